cla_pipe_addsub: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the combinational CLA adder.
- Operand width and pipeline depth are generic. Supports add/sub mode and returns status flags.
- Valid/ready handshake on both sides with backpressure.
- Sits between operand-issue logic and the writeback/flag consumer in the multi-cycle datapath.

---
 rtl/cla_pkg.sv | 22 ++
 rtl/cla_group.sv | 38 +++
 rtl/cla_pipe_addsub.sv | 152 +++++++++++++++
 tb/tb_cla_pipe_addsub.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and elaboration helpers for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

  // Control half of each stage payload; the data half is sized per stage in the top.
  typedef struct packed {
    logic valid;
    logic carry;
  } cla_ctrl_t;

  function automatic int cla_slice_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic int cla_group_cnt(input int width, input int stages, input int group);
    return width / (stages * group);
  endfunction

  function automatic bit cla_cfg_ok(input int width, input int stages, input int group);
    return (stages > 32'sd0) && (group > 32'sd0) && ((width % (stages * group)) == 32'sd0);
  endfunction

endpackage

// File: rtl/cla_group.sv
// GROUP-bit carry-lookahead block: sum plus group generate/propagate for the next lookahead level.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             gen,
  output logic             prop
);

  logic [GROUP-1:0] g_s;
  logic [GROUP-1:0] p_s;
  logic [GROUP-1:0] c_s;
  logic             gen_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // Each bit carry is expanded from cin directly, so synthesis sees flat sum-of-products.
  always_comb begin
    c_s   = '0;
    gen_s = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      c_s[i] = cin;
      for (int j = 0; j < i; j++) begin
        c_s[i] = g_s[j] | (p_s[j] & c_s[i]);
      end
      gen_s = g_s[i] | (p_s[i] & gen_s);
    end
  end

  assign sum  = p_s ^ c_s;
  assign gen  = gen_s;
  assign prop = &p_s;

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one slice per stage, valid/ready with global stall.
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int GROUP  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero,
  output logic             o_neg
);

  localparam int W_S = cla_slice_w(WIDTH, STAGES);
  localparam int NG  = cla_group_cnt(WIDTH, STAGES, GROUP);

  if (!cla_cfg_ok(WIDTH, STAGES, GROUP)) begin : g_cfg_check
    $error("cla_pipe_addsub: WIDTH must be a multiple of STAGES*GROUP");
  end

  logic             en_s;
  logic             out_valid_r;
  logic [WIDTH-1:0] res_sum_r;
  logic             res_cout_r;
  logic             res_ovf_r;
  logic             res_zero_r;
  logic             res_neg_r;

  // Whole pipe advances together; it only freezes when a finished result is waiting.
  assign en_s    = !out_valid_r || i_ready;
  assign o_ready = en_s;
  assign o_valid = out_valid_r;
  assign o_sum   = res_sum_r;
  assign o_cout  = res_cout_r;
  assign o_ovf   = res_ovf_r;
  assign o_zero  = res_zero_r;
  assign o_neg   = res_neg_r;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int LO     = k * W_S;
    localparam int REM_IN = WIDTH - LO;

    cla_ctrl_t          ctl_in_s;
    logic [REM_IN-1:0]  a_in_s;
    logic [REM_IN-1:0]  b_in_s;
    logic [LO+W_S-1:0]  sum_in_s;
    logic [W_S-1:0]     s_s;
    logic [NG-1:0]      g_s;
    logic [NG-1:0]      p_s;
    logic [NG:0]        c_s;

    if (k == 0) begin : g_src
      assign a_in_s   = i_a;
      assign b_in_s   = i_sub ? ~i_b : i_b;
      assign ctl_in_s = '{valid: i_valid, carry: i_sub | i_cin};
      assign sum_in_s = s_s;
    end else begin : g_chain
      assign a_in_s   = stg[k-1].g_mid.a_rem_r;
      assign b_in_s   = stg[k-1].g_mid.b_rem_r;
      assign ctl_in_s = stg[k-1].g_mid.ctl_r;
      assign sum_in_s = {s_s, stg[k-1].g_mid.sum_r};
    end

    for (genvar g = 0; g < NG; g++) begin : grp
      cla_group #(.GROUP(GROUP)) u_grp (
        .a    (a_in_s[g*GROUP +: GROUP]),
        .b    (b_in_s[g*GROUP +: GROUP]),
        .cin  (c_s[g]),
        .sum  (s_s[g*GROUP +: GROUP]),
        .gen  (g_s[g]),
        .prop (p_s[g])
      );
    end

    // Second lookahead level: every group carry is a flat function of the slice carry-in.
    always_comb begin
      c_s = '0;
      for (int i = 0; i <= NG; i++) begin
        c_s[i] = ctl_in_s.carry;
        for (int j = 0; j < i; j++) begin
          c_s[i] = g_s[j] | (p_s[j] & c_s[i]);
        end
      end
    end

    if (k < STAGES - 1) begin : g_mid
      localparam int REM_OUT = REM_IN - W_S;

      cla_ctrl_t           ctl_r;
      logic [REM_OUT-1:0]  a_rem_r;
      logic [REM_OUT-1:0]  b_rem_r;
      logic [LO+W_S-1:0]   sum_r;

      // Stage register: valid moves on every enabled edge, payload only for live transfers.
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          ctl_r   <= '0;
          a_rem_r <= '0;
          b_rem_r <= '0;
          sum_r   <= '0;
        end else if (en_s) begin
          ctl_r.valid <= ctl_in_s.valid;
          if (ctl_in_s.valid) begin
            ctl_r.carry <= c_s[NG];
            a_rem_r     <= a_in_s[REM_IN-1:W_S];
            b_rem_r     <= b_in_s[REM_IN-1:W_S];
            sum_r       <= sum_in_s;
          end
        end
      end
    end else begin : g_last
      logic c_msb_s;

      // Carry into the MSB is recovered from the MSB sum bit and its operands.
      assign c_msb_s = s_s[W_S-1] ^ a_in_s[REM_IN-1] ^ b_in_s[REM_IN-1];

      // Output register: result and flags stay frozen while the consumer stalls.
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          out_valid_r <= 1'b0;
          res_sum_r   <= '0;
          res_cout_r  <= 1'b0;
          res_ovf_r   <= 1'b0;
          res_zero_r  <= 1'b0;
          res_neg_r   <= 1'b0;
        end else if (en_s) begin
          out_valid_r <= ctl_in_s.valid;
          if (ctl_in_s.valid) begin
            res_sum_r  <= sum_in_s;
            res_cout_r <= c_s[NG];
            res_ovf_r  <= c_msb_s ^ c_s[NG];
            res_zero_r <= ~|sum_in_s;
            res_neg_r  <= s_s[W_S-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Randomised bench for cla_pipe_addsub: directed corner cases, streaming, backpressure and reset flush.
module tb_cla_pipe_addsub;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
  localparam int GROUP  = 4;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;
  localparam longint UMAX = 64'sd4294967295;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_cin;
  logic        i_sub;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_sum;
  logic        o_cout;
  logic        o_ovf;
  logic        o_zero;
  logic        o_neg;

  res_t exp_q[$];
  res_t mon_e;
  res_t held;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   n_out        = 0;
  int   base;
  int   edges;

  cla_pipe_addsub #(.WIDTH(WIDTH), .STAGES(STAGES), .GROUP(GROUP)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_cin   (i_cin),
    .i_sub   (i_sub),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sum   (o_sum),
    .o_cout  (o_cout),
    .o_ovf   (o_ovf),
    .o_zero  (o_zero),
    .o_neg   (o_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands' unsigned and signed values.
  function automatic res_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                     input logic cin, input logic sub);
    res_t   r;
    longint ua, ub, sa, sb, ur, sr;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      ur     = ua - ub;
      sr     = sa - sb;
      r.cout = (ua >= ub);
    end else begin
      ur     = ua + ub + longint'(cin);
      sr     = sa + sb + longint'(cin);
      r.cout = (ur > UMAX);
    end
    r.sum  = ur[31:0];
    r.ovf  = (sr > SMAX) || (sr < SMIN);
    r.zero = (r.sum == 32'd0);
    r.neg  = r.sum[31];
    return r;
  endfunction

  // Scoreboard: record accepted inputs, compare every consumed result in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (i_valid && o_ready) begin
        exp_q.push_back(ref_model(i_a, i_b, i_cin, i_sub));
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_result", 64'(o_valid), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_result", 64'({o_sum, o_cout, o_ovf, o_zero, o_neg}), 64'(mon_e));
          n_out = n_out + 1;
        end
      end
    end
  end

  task automatic check_dut(input string tag, input res_t exp);
    check({tag, ".sum"},  64'(o_sum),  64'(exp.sum));
    check({tag, ".cout"}, 64'(o_cout), 64'(exp.cout));
    check({tag, ".ovf"},  64'(o_ovf),  64'(exp.ovf));
    check({tag, ".zero"}, 64'(o_zero), 64'(exp.zero));
    check({tag, ".neg"},  64'(o_neg),  64'(exp.neg));
  endtask

  // Called just after an edge; returns once the transfer has been taken.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    int guard;
    guard   = 0;
    i_valid = 1'b1;
    i_a     = a;
    i_b     = b;
    i_cin   = cin;
    i_sub   = sub;
    @(negedge clk);
    while (!o_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!o_ready) check("accept_timeout", 64'(o_ready), 64'd1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_a     = $urandom;
    i_b     = $urandom;
  endtask

  // Counts edges from the accepting edge until o_valid is seen.
  task automatic wait_valid(output int n);
    n = 1;
    while (!o_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!o_valid) check("valid_timeout", 64'(o_valid), 64'd1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge clk);
      #1;
      g++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_a     = 32'd0;
    i_b     = 32'd0;
    i_cin   = 1'b0;
    i_sub   = 1'b0;
    i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(o_valid), 64'd0);
    check_dut("rst", '0);
    rst_n = 1'b1;
    check("rst_ready", 64'(o_ready), 64'd1);

    // Directed corner cases with latency measurement.
    i_ready = 1'b1;
    drive(32'h3, 32'h5, 1'b0, 1'b0);
    wait_valid(edges);
    check("lat_add", 64'(edges), 64'd4);
    check_dut("add3p5", '{sum: 32'h8, cout: 1'b0, ovf: 1'b0, zero: 1'b0, neg: 1'b0});

    drive(32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
    wait_valid(edges);
    check("lat_wrap", 64'(edges), 64'd4);
    check_dut("wrap", '{sum: 32'h0, cout: 1'b1, ovf: 1'b0, zero: 1'b1, neg: 1'b0});

    drive(32'h80000000, 32'h1, 1'b0, 1'b1);
    wait_valid(edges);
    check_dut("sub_ovf", '{sum: 32'h7FFFFFFF, cout: 1'b1, ovf: 1'b1, zero: 1'b0, neg: 1'b0});

    drive(32'h1, 32'h2, 1'b1, 1'b1);
    wait_valid(edges);
    check_dut("sub_borrow", '{sum: 32'hFFFFFFFF, cout: 1'b0, ovf: 1'b0, zero: 1'b0, neg: 1'b1});
    drain();

    // Back-to-back stream: last of 16 results must appear 3 edges after the last accept.
    @(posedge clk);
    #1;
    base = n_out;
    for (int i = 0; i < 16; i++) begin
      drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    edges = 0;
    while (n_out < base + 16 && edges < 50) begin
      @(negedge clk);
      #1;
      edges++;
    end
    check("stream_tail_edges", 64'(edges), 64'd4);
    check("stream_count", 64'(n_out - base), 64'd16);

    // Backpressure: fill the pipe, stall 5 cycles with a pending input, then release.
    @(posedge clk);
    #1;
    base    = n_out;
    i_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    check("bp_full_valid", 64'(o_valid), 64'd1);
    held    = {o_sum, o_cout, o_ovf, o_zero, o_neg};
    i_valid = 1'b1;
    i_a     = $urandom;
    i_b     = $urandom;
    i_cin   = 1'b1;
    i_sub   = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_ready", 64'(o_ready), 64'd0);
      check("bp_valid", 64'(o_valid), 64'd1);
      check("bp_hold", 64'({o_sum, o_cout, o_ovf, o_zero, o_neg}), 64'(held));
    end
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    drain();
    check("bp_count", 64'(n_out - base), 64'd5);

    // Random traffic with idle gaps.
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();

    // Reset with three transactions in flight: all must be discarded.
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_valid", 64'(o_valid), 64'd0);
    check_dut("midrst", '0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base  = n_out;
    repeat (8) begin
      @(negedge clk);
      check("post_rst_valid", 64'(o_valid), 64'd0);
    end
    check("post_rst_count", 64'(n_out - base), 64'd0);

    @(posedge clk);
    #1;
    drive(32'h7, 32'h9, 1'b1, 1'b0);
    wait_valid(edges);
    check("lat_after_rst", 64'(edges), 64'd4);
    check_dut("after_rst", '{sum: 32'h11, cout: 1'b0, ovf: 1'b0, zero: 1'b0, neg: 1'b0});
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
